mt9v034_lvds_frame_decode: RTL

//  Downstream stage of the LVDS bit aligner. Takes aligned 18-bit words and decodes the embedded
//  FV/LV/pixel fields into a framed pixel stream with SOF/EOL/EOF markers.

---
 rtl/mt9v034_lvds_frame_decode_pkg.sv | 34 +++
 rtl/mt9v034_lvds_frame_decode.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/mt9v034_lvds_frame_decode_pkg.sv
// Shared definitions for the MT9V034 LVDS receive path: word bit positions and frame FSM states.
// Latency: none (definitions only).
// Backpressure: none (definitions only). The bit aligner uses the same word layout.
package mt9v034_lvds_pkg;

    localparam int unsigned WORD_W = 18;
    localparam int unsigned PIX_W  = 10;

    // Aligned word layout: [0]=start(1) [10:1]=pixel [11]=LV [12]=FV [16:13]=rsvd [17]=stop(0)
    localparam int unsigned START_BIT = 0;
    localparam int unsigned PIX_LSB   = 1;
    localparam int unsigned PIX_MSB   = 10;
    localparam int unsigned LV_BIT    = 11;
    localparam int unsigned FV_BIT    = 12;
    localparam int unsigned STOP_BIT  = 17;

    // One-hot state indices
    localparam int unsigned S_WAIT_VB_IDX = 0;
    localparam int unsigned S_WAIT_FV_IDX = 1;
    localparam int unsigned S_BLANK_IDX   = 2;
    localparam int unsigned S_LINE_IDX    = 3;

    typedef enum logic [3:0] {
        S_WAIT_VB = 4'(1 << S_WAIT_VB_IDX),
        S_WAIT_FV = 4'(1 << S_WAIT_FV_IDX),
        S_BLANK   = 4'(1 << S_BLANK_IDX),
        S_LINE    = 4'(1 << S_LINE_IDX)
    } frame_state_t;

    function automatic logic [9:0] sat_inc10(input logic [9:0] v);
        return (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

endpackage

// File: rtl/mt9v034_lvds_frame_decode.sv
// Decodes aligned LVDS words into a framed pixel stream with SOF/EOL/EOF and checks frame geometry.
// Latency: 2 cycles dlo_i->pix_data_o; a line's last pixel leaves the cycle after the LV/FV-fall word.
// Backpressure: none; the sensor cannot be stalled, so any input gap inside a frame is a sync loss.
// Ports: dlo_clk/rst_n clock and async active-low reset; dlo_valid_i/align_err_i/dlo_i from aligner;
//        pix_* pixel stream; line_cnt_o/frame_cnt_o counters; len/cnt/sync_err_o sticky error flags.
module mt9v034_lvds_frame_decode
    import mt9v034_lvds_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 752,
    parameter int unsigned V_ACTIVE = 480
) (
    input  logic              dlo_clk,
    input  logic              rst_n,
    input  logic              align_err_i,
    input  logic              dlo_valid_i,
    input  logic [WORD_W-1:0] dlo_i,
    output logic              pix_valid_o,
    output logic [PIX_W-1:0]  pix_data_o,
    output logic              pix_sof_o,
    output logic              pix_eol_o,
    output logic              pix_eof_o,
    output logic [9:0]        line_cnt_o,
    output logic [15:0]       frame_cnt_o,
    output logic              len_err_o,
    output logic              cnt_err_o,
    output logic              sync_err_o
);

    localparam logic [9:0] H_ACT10 = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT10 = 10'(V_ACTIVE);

    frame_state_t     state_q, state_d;
    logic             accept, framing_ok, lv, fv;
    logic [PIX_W-1:0] word_pix;
    logic             load_pix, emit_pix, line_end, frame_end, sync_loss;
    logic             first_pix, sof_pend_q, sof_pend_d;
    logic [PIX_W-1:0] hold_dat_q;
    logic             hold_sof_q;
    logic [9:0]       pix_cnt_q;
    logic [9:0]       frame_lines;
    logic             unused_rsvd;

    assign accept     = dlo_valid_i & ~align_err_i;
    assign framing_ok = dlo_i[START_BIT] & ~dlo_i[STOP_BIT];
    assign lv         = dlo_i[LV_BIT];
    assign fv         = dlo_i[FV_BIT];
    assign word_pix   = dlo_i[PIX_MSB:PIX_LSB];
    assign unused_rsvd = ^dlo_i[16:13];

    always_ff @(posedge dlo_clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_WAIT_VB;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        load_pix  = 1'b0;
        emit_pix  = 1'b0;
        line_end  = 1'b0;
        frame_end = 1'b0;
        sync_loss = 1'b0;
        // Inside a frame every cycle must carry a good word; anything else drops to re-lock.
        if (accept && !framing_ok)
            sync_loss = 1'b1;
        else if (!accept && (state_q[S_BLANK_IDX] || state_q[S_LINE_IDX]))
            sync_loss = 1'b1;

        if (sync_loss) begin
            state_d = S_WAIT_VB;
        end else if (accept) begin
            unique case (state_q)
                S_WAIT_VB: if (!fv) state_d = S_WAIT_FV;
                S_WAIT_FV: begin
                    if (fv && lv) begin
                        state_d  = S_LINE;
                        load_pix = 1'b1;
                    end else if (fv) begin
                        state_d = S_BLANK;
                    end
                end
                S_BLANK: begin
                    if (!fv) begin
                        frame_end = 1'b1;
                        state_d   = S_WAIT_FV;
                    end else if (lv) begin
                        state_d  = S_LINE;
                        load_pix = 1'b1;
                    end
                end
                S_LINE: begin
                    // The held pixel always leaves; the new word decides whether it was the last.
                    emit_pix = 1'b1;
                    if (!fv) begin
                        line_end  = 1'b1;
                        frame_end = 1'b1;
                        state_d   = S_WAIT_FV;
                    end else if (!lv) begin
                        line_end = 1'b1;
                        state_d  = S_BLANK;
                    end else begin
                        load_pix = 1'b1;
                    end
                end
                default: state_d = S_WAIT_VB;
            endcase
        end
    end

    // SOF belongs to the first pixel after S_WAIT_FV, even when blanking words come in between.
    assign first_pix  = load_pix & (state_q[S_WAIT_FV_IDX] | sof_pend_q);
    assign sof_pend_d = (state_d == S_BLANK) & (state_q[S_WAIT_FV_IDX] | sof_pend_q);

    // A frame that ends before its first pixel has completed zero lines, whatever line_cnt_o still shows.
    assign frame_lines = sof_pend_q ? 10'd0 :
                         line_end   ? sat_inc10(line_cnt_o) : line_cnt_o;

    always_ff @(posedge dlo_clk or negedge rst_n) begin
        if (!rst_n) begin
            sof_pend_q  <= 1'b0;
            hold_dat_q  <= '0;
            hold_sof_q  <= 1'b0;
            pix_cnt_q   <= '0;
            pix_valid_o <= 1'b0;
            pix_data_o  <= '0;
            pix_sof_o   <= 1'b0;
            pix_eol_o   <= 1'b0;
            pix_eof_o   <= 1'b0;
            line_cnt_o  <= '0;
            frame_cnt_o <= '0;
            len_err_o   <= 1'b0;
            cnt_err_o   <= 1'b0;
            sync_err_o  <= 1'b0;
        end else begin
            sof_pend_q  <= sof_pend_d;
            pix_valid_o <= emit_pix;
            pix_sof_o   <= emit_pix & hold_sof_q;
            pix_eol_o   <= emit_pix & line_end;
            pix_eof_o   <= emit_pix & frame_end;
            if (emit_pix) pix_data_o <= hold_dat_q;

            if (load_pix) begin
                hold_dat_q <= word_pix;
                hold_sof_q <= first_pix;
                pix_cnt_q  <= state_q[S_LINE_IDX] ? sat_inc10(pix_cnt_q) : 10'd1;
            end

            if (first_pix)     line_cnt_o <= '0;
            else if (line_end) line_cnt_o <= sat_inc10(line_cnt_o);

            if (line_end && pix_cnt_q != H_ACT10) len_err_o <= 1'b1;

            if (frame_end) begin
                if (frame_lines != V_ACT10) cnt_err_o   <= 1'b1;
                else                        frame_cnt_o <= frame_cnt_o + 16'd1;
            end

            if (sync_loss || align_err_i) sync_err_o <= 1'b1;
        end
    end

endmodule
